// File: rtl/alu_defs_pkg.sv
// Shared definitions for the ALU issue stage: ALU control codes, alu_op classes,
// R-type funct values, operand-B selects and the issue FSM states.
package alu_defs_pkg;

    localparam logic [3:0] ALU_AND     = 4'b0000;
    localparam logic [3:0] ALU_OR      = 4'b0001;
    localparam logic [3:0] ALU_ADD     = 4'b0010;
    localparam logic [3:0] ALU_SUB     = 4'b0011;
    localparam logic [3:0] ALU_SLT     = 4'b0100;
    localparam logic [3:0] ALU_NOR     = 4'b0101;
    localparam logic [3:0] ALU_SLL     = 4'b1000;
    localparam logic [3:0] ALU_SRL     = 4'b1001;
    localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

    localparam logic [1:0] OP_MEM    = 2'b00;
    localparam logic [1:0] OP_BRANCH = 2'b01;
    localparam logic [1:0] OP_RTYPE  = 2'b10;
    localparam logic [1:0] OP_ORI    = 2'b11;

    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;
    localparam logic [5:0] FUNCT_SLL = 6'b000000;
    localparam logic [5:0] FUNCT_SRL = 6'b000010;

    typedef enum logic [1:0] {
        B_RT       = 2'd0,
        B_SEXT_IMM = 2'd1,
        B_ZEXT_IMM = 2'd2,
        B_SHAMT    = 2'd3
    } b_sel_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } issue_state_e;

    // Unsupported funct values map to ALU_ILLEGAL, which the ALU treats as "produce 0".
    function automatic logic [3:0] rtype_ctrl(input logic [5:0] funct);
        logic [3:0] ctrl;
        case (funct)
            FUNCT_AND: ctrl = ALU_AND;
            FUNCT_OR:  ctrl = ALU_OR;
            FUNCT_ADD: ctrl = ALU_ADD;
            FUNCT_SUB: ctrl = ALU_SUB;
            FUNCT_SLT: ctrl = ALU_SLT;
            FUNCT_NOR: ctrl = ALU_NOR;
            FUNCT_SLL: ctrl = ALU_SLL;
            FUNCT_SRL: ctrl = ALU_SRL;
            default:   ctrl = ALU_ILLEGAL;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of alu_op/funct into the ALU control code, the operand
// selects and the illegal-funct flag; used on the input side before capture.
module alu_ctrl_decode
    import alu_defs_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] control,
    output b_sel_e     b_sel,
    output logic       a_from_rt,
    output logic       illegal
);

    always_comb begin
        control   = ALU_ADD;
        b_sel     = B_RT;
        a_from_rt = 1'b0;
        illegal   = 1'b0;
        case (alu_op)
            OP_MEM: begin
                control = ALU_ADD;
                b_sel   = B_SEXT_IMM;
            end
            OP_BRANCH: begin
                control = ALU_SUB;
                b_sel   = B_RT;
            end
            OP_ORI: begin
                control = ALU_OR;
                b_sel   = B_ZEXT_IMM;
            end
            OP_RTYPE: begin
                control = rtype_ctrl(funct);
                illegal = (control == ALU_ILLEGAL);
                // Shifts operate on rt by the immediate shift amount.
                if (funct == FUNCT_SLL || funct == FUNCT_SRL) begin
                    a_from_rt = 1'b1;
                    b_sel     = B_SHAMT;
                end
            end
            default: begin
                control = ALU_ADD;
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Execute-issue stage: decodes, selects and registers ALU operands behind a
// valid/ready handshake with a one-entry skid. Optional forwarding: ALU_ISSUE_FWD_EN.
module alu_issue_stage
    import alu_defs_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        alu_op,
    input  logic [5:0]        funct,
    input  logic [4:0]        shamt,
    input  logic [15:0]       imm,
    input  logic [4:0]        rs_idx,
    input  logic [4:0]        rt_idx,
    input  logic [4:0]        rd_idx,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic              fwd_valid,
    input  logic [4:0]        fwd_idx,
    input  logic [DATA_W-1:0] fwd_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        control_signal,
    output logic [DATA_W-1:0] in_world_a,
    output logic [DATA_W-1:0] in_world_b,
    output logic [4:0]        out_rd,
    output logic              out_illegal
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // the producer holds its payload stable while valid is high and ready is low.

    issue_state_e      state;
    issue_state_e      next_state;

    logic [3:0]        dec_control;
    b_sel_e            dec_b_sel;
    logic              dec_a_from_rt;
    logic              dec_illegal;

    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [DATA_W-1:0] new_a;
    logic [DATA_W-1:0] new_b;

    logic [3:0]        skid_control;
    logic [DATA_W-1:0] skid_a;
    logic [DATA_W-1:0] skid_b;
    logic [4:0]        skid_rd;
    logic              skid_illegal;

    logic              in_fire;
    logic              out_fire;
    logic              load_out_new;
    logic              load_out_skid;
    logic              load_skid;

    alu_ctrl_decode u_decode (
        .alu_op    (alu_op),
        .funct     (funct),
        .control   (dec_control),
        .b_sel     (dec_b_sel),
        .a_from_rt (dec_a_from_rt),
        .illegal   (dec_illegal)
    );

`ifdef ALU_ISSUE_FWD_EN
    // Forwarding is resolved once at capture; entries already held keep their operands.
    assign rs_val = (fwd_valid && (fwd_idx != 5'd0) && (fwd_idx == rs_idx)) ? fwd_data : rs_data;
    assign rt_val = (fwd_valid && (fwd_idx != 5'd0) && (fwd_idx == rt_idx)) ? fwd_data : rt_data;
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwd_valid, fwd_idx, fwd_data, rs_idx, rt_idx};
    assign rs_val = rs_data;
    assign rt_val = rt_data;
`endif

    assign new_a = dec_a_from_rt ? rt_val : rs_val;

    always_comb begin
        new_b = rt_val;
        case (dec_b_sel)
            B_RT:       new_b = rt_val;
            B_SEXT_IMM: new_b = {{(DATA_W-16){imm[15]}}, imm};
            B_ZEXT_IMM: new_b = {{(DATA_W-16){1'b0}}, imm};
            B_SHAMT:    new_b = {{(DATA_W-5){1'b0}}, shamt};
            default:    new_b = rt_val;
        endcase
    end

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_comb begin
        next_state    = state;
        load_out_new  = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        if (flush) begin
            next_state = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        next_state   = ST_FULL;
                        load_out_new = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (in_fire && out_fire) begin
                        load_out_new = 1'b1;
                    end else if (in_fire) begin
                        next_state = ST_SKID;
                        load_skid  = 1'b1;
                    end else if (out_fire) begin
                        next_state = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (out_fire) begin
                        next_state    = ST_FULL;
                        load_out_skid = 1'b1;
                    end
                end
                default: begin
                    next_state = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_EMPTY;
            in_ready       <= 1'b1;
            out_valid      <= 1'b0;
            control_signal <= ALU_AND;
            in_world_a     <= '0;
            in_world_b     <= '0;
            out_rd         <= '0;
            out_illegal    <= 1'b0;
            skid_control   <= ALU_AND;
            skid_a         <= '0;
            skid_b         <= '0;
            skid_rd        <= '0;
            skid_illegal   <= 1'b0;
        end else begin
            state     <= next_state;
            in_ready  <= (next_state != ST_SKID);
            out_valid <= (next_state != ST_EMPTY);
            if (load_out_new) begin
                control_signal <= dec_control;
                in_world_a     <= new_a;
                in_world_b     <= new_b;
                out_rd         <= rd_idx;
                out_illegal    <= dec_illegal;
            end else if (load_out_skid) begin
                control_signal <= skid_control;
                in_world_a     <= skid_a;
                in_world_b     <= skid_b;
                out_rd         <= skid_rd;
                out_illegal    <= skid_illegal;
            end
            if (load_skid) begin
                skid_control <= dec_control;
                skid_a       <= new_a;
                skid_b       <= new_b;
                skid_rd      <= rd_idx;
                skid_illegal <= dec_illegal;
            end
        end
    end

endmodule
